// File: rtl/bullet_pool_ctrl_pkg.sv
// Shared game constants and types for the player bullet pool.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: bullet_state_t fire-FSM encoding, default pool sizing, frame counts, datapath widths.
package bullet_pool_ctrl_pkg;

  // Legacy numeric state codes; the enum below is pinned to them so existing
  // debug tooling that decodes the raw 2-bit value keeps working.
  localparam logic [1:0] ST_READY    = 2'd0;
  localparam logic [1:0] ST_COOLDOWN = 2'd1;
  localparam logic [1:0] ST_RELOAD   = 2'd2;

  typedef enum logic [1:0] {
    READY    = ST_READY,
    COOLDOWN = ST_COOLDOWN,
    RELOAD   = ST_RELOAD
  } bullet_state_t;

  localparam int DEF_N_SLOTS         = 4;
  localparam int DEF_MAG_SIZE        = 6;
  localparam int DEF_COOLDOWN_FRAMES = 8;
  localparam int DEF_RELOAD_FRAMES   = 30;

  localparam int AMMO_W      = 4;
  localparam int HIT_IDX_W   = 3;
  localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/bullet_pool_ctrl_rr_hit_arbiter.sv
// Serialises per-slot hit pulses into one hit event per clk, round-robin fair.
// Latency: a pending hit is granted the cycle after capture; o_hit_valid/o_hit_idx are registered one cycle after the grant.
// Backpressure: none downstream; hits accumulate in a sticky pending vector (duplicates on a pending bit merge).
// Ports: clk, rst_n (async active-low), i_slot_hit[N_SLOTS] pulses in, o_hit_valid pulse + o_hit_idx out.
module bullet_pool_ctrl_rr_hit_arbiter
  import bullet_pool_ctrl_pkg::*;
#(
  parameter int N_SLOTS = DEF_N_SLOTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SLOTS-1:0]   i_slot_hit,
  output logic                 o_hit_valid,
  output logic [HIT_IDX_W-1:0] o_hit_idx
);

  localparam int IW = $clog2(N_SLOTS);

  logic [N_SLOTS-1:0]   r_pend;
  logic [IW-1:0]        r_last;
  logic                 r_hit_valid;
  logic [HIT_IDX_W-1:0] r_hit_idx;

  logic                 w_gnt_vld;
  logic [IW-1:0]        w_gnt_idx;
  logic [N_SLOTS-1:0]   w_gnt_oh;

  // base + off modulo N_SLOTS; off never exceeds N_SLOTS so one wrap suffices.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_SLOTS) s = s - N_SLOTS;
    return IW'(s);
  endfunction

  // Search starts one past the last grant, so every slot is reached within N_SLOTS grants.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= N_SLOTS; k++) begin
      if (!w_gnt_vld && r_pend[wrap_idx(r_last, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap_idx(r_last, k);
      end
    end
  end

  assign w_gnt_oh = w_gnt_vld ? (N_SLOTS'(1) << w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_last      <= IW'(N_SLOTS - 1);
      r_hit_valid <= 1'b0;
      r_hit_idx   <= '0;
    end else begin
      // Clear the granted bit first, then OR new hits: a hit landing on the bit
      // being granted this cycle is a fresh event and must stay pending.
      r_pend      <= (r_pend & ~w_gnt_oh) | i_slot_hit;
      r_hit_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_last    <= w_gnt_idx;
        r_hit_idx <= HIT_IDX_W'(w_gnt_idx);
      end
    end
  end

  assign o_hit_valid = r_hit_valid;
  assign o_hit_idx   = r_hit_idx;

endmodule

// File: rtl/bullet_pool_ctrl.sv
// Player bullet pool controller: fire gating (cooldown/magazine/reload), free-slot launch, hit serialisation.
// Latency: fire_en one clk after the qualifying frame_tick; hit report two clks after the slot_hit pulse when uncontended.
// Backpressure: firing is refused (not queued) when busy, guarding or out of ammo; hits queue in the arbiter.
// Ports: clk, rst_n; i_frame_tick/i_attack/i_defend/i_reload_req player controls; i_slot_busy/i_slot_hit from slots;
//        o_fire_en one-hot launch, o_ammo, o_reloading, o_cooling, o_hit_valid/o_hit_idx serialised hits.
module bullet_pool_ctrl
  import bullet_pool_ctrl_pkg::*;
#(
  parameter int N_SLOTS         = DEF_N_SLOTS,
  parameter int MAG_SIZE        = DEF_MAG_SIZE,
  parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
  parameter int RELOAD_FRAMES   = DEF_RELOAD_FRAMES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_frame_tick,
  input  logic                 i_attack,
  input  logic                 i_defend,
  input  logic                 i_reload_req,
  input  logic [N_SLOTS-1:0]   i_slot_busy,
  input  logic [N_SLOTS-1:0]   i_slot_hit,
  output logic [N_SLOTS-1:0]   o_fire_en,
  output logic [AMMO_W-1:0]    o_ammo,
  output logic                 o_reloading,
  output logic                 o_cooling,
  output logic                 o_hit_valid,
  output logic [HIT_IDX_W-1:0] o_hit_idx
);

  localparam logic [AMMO_W-1:0]      MAG     = AMMO_W'(MAG_SIZE);
  localparam logic [FRAME_CNT_W-1:0] CD_LAST = FRAME_CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] RL_LAST = FRAME_CNT_W'(RELOAD_FRAMES - 1);

  bullet_state_t          r_state;
  logic [AMMO_W-1:0]      r_ammo;
  logic [FRAME_CNT_W-1:0] r_cnt;
  logic [N_SLOTS-1:0]     r_fire_en;

  logic [N_SLOTS-1:0]     w_free;
  logic [N_SLOTS-1:0]     w_fire_oh;
  logic                   w_fire;

  assign w_free    = ~i_slot_busy;
  // Isolate the lowest set bit: the lowest-index free slot as a one-hot.
  assign w_fire_oh = w_free & (~w_free + N_SLOTS'(1));
  assign w_fire    = i_frame_tick && (r_state == READY) && i_attack && !i_defend &&
                     (r_ammo != '0) && (|w_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= READY;
      r_ammo    <= MAG;
      r_cnt     <= '0;
      r_fire_en <= '0;
    end else begin
      r_fire_en <= '0;
      if (i_frame_tick) begin
        case (r_state)
          READY: begin
            if (w_fire) begin
              r_fire_en <= w_fire_oh;
              r_ammo    <= r_ammo - AMMO_W'(1);
              r_state   <= (r_ammo == AMMO_W'(1)) ? RELOAD : COOLDOWN;
              r_cnt     <= '0;
            end else if (i_reload_req && (r_ammo < MAG)) begin
              r_state <= RELOAD;
              r_cnt   <= '0;
            end
          end
          COOLDOWN: begin
            if (r_cnt == CD_LAST) begin
              r_state <= READY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + FRAME_CNT_W'(1);
            end
          end
          RELOAD: begin
            if (r_cnt == RL_LAST) begin
              r_ammo  <= MAG;
              r_state <= READY;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + FRAME_CNT_W'(1);
            end
          end
          default: begin
            r_state <= READY;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_fire_en   = r_fire_en;
  assign o_ammo      = r_ammo;
  assign o_reloading = (r_state == RELOAD);
  assign o_cooling   = (r_state == COOLDOWN);

  bullet_pool_ctrl_rr_hit_arbiter #(
    .N_SLOTS (N_SLOTS)
  ) u_hit_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_slot_hit  (i_slot_hit),
    .o_hit_valid (o_hit_valid),
    .o_hit_idx   (o_hit_idx)
  );

endmodule

// File: tb/tb_bullet_pool_ctrl.sv
// Self-checking bench for bullet_pool_ctrl: directed scenarios followed by random traffic.
// Reference model counts remaining cooldown/reload frames down and keeps hits in a pending array.
// All outputs are sampled 1ns after the rising clock edge.
module tb_bullet_pool_ctrl;

  localparam int N   = 4;
  localparam int MAG = 6;
  localparam int CD  = 8;
  localparam int RL  = 30;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic         tick = 1'b0, attack = 1'b0, defend = 1'b0, reload_req = 1'b0;
  logic [N-1:0] busy = '0, hit = '0;

  logic [N-1:0] fire_en;
  logic [3:0]   ammo;
  logic         reloading, cooling, hv;
  logic [2:0]   hidx;

  int n_chk  = 0;
  int n_pass = 0;
  int fire_cnt = 0;

  // Reference model state
  int           m_ammo, m_cool, m_reload, m_last;
  logic [N-1:0] m_pend;
  logic [N-1:0] e_fire;
  logic         e_hv;
  int           e_hidx;

  always #5 clk = ~clk;

  bullet_pool_ctrl #(
    .N_SLOTS         (N),
    .MAG_SIZE        (MAG),
    .COOLDOWN_FRAMES (CD),
    .RELOAD_FRAMES   (RL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (tick),
    .i_attack     (attack),
    .i_defend     (defend),
    .i_reload_req (reload_req),
    .i_slot_busy  (busy),
    .i_slot_hit   (hit),
    .o_fire_en    (fire_en),
    .o_ammo       (ammo),
    .o_reloading  (reloading),
    .o_cooling    (cooling),
    .o_hit_valid  (hv),
    .o_hit_idx    (hidx)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_ammo = MAG; m_cool = 0; m_reload = 0; m_last = N - 1;
    m_pend = '0; e_fire = '0; e_hv = 1'b0; e_hidx = 0;
  endtask

  // Advance the model by one clk using the inputs the DUT sampled at this edge.
  task automatic model_step();
    int g;
    int f;
    e_fire = '0;
    e_hv   = 1'b0;
    g = -1;
    for (int k = 1; k <= N; k++)
      if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
    if (g >= 0) begin
      e_hv = 1'b1; e_hidx = g; m_last = g; m_pend[g] = 1'b0;
    end
    m_pend = m_pend | hit;
    if (tick) begin
      if (m_reload > 0) begin
        m_reload--;
        if (m_reload == 0) m_ammo = MAG;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (attack && !defend && m_ammo > 0 && busy != '1) begin
        f = 0;
        for (int i = N - 1; i >= 0; i--) if (!busy[i]) f = i;
        e_fire = N'(1) << f;
        m_ammo--;
        if (m_ammo == 0) m_reload = RL;
        else             m_cool = CD;
      end else if (reload_req && m_ammo < MAG) begin
        m_reload = RL;
      end
    end
  endtask

  // One clock: model step, compare every output, then drop one-cycle pulses.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("fire_en",   fire_en,   e_fire);
    chk("ammo",      ammo,      m_ammo);
    chk("reloading", reloading, m_reload > 0);
    chk("cooling",   cooling,   m_cool > 0);
    chk("hit_valid", hv,        e_hv);
    if (e_hv) chk("hit_idx", hidx, e_hidx);
    if (fire_en != '0) fire_cnt++;
    tick = 1'b0;
    hit  = '0;
  endtask

  task automatic tick_cyc();
    tick = 1'b1;
    cyc();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      tick_cyc();
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic last_tick;
    model_reset();
    #1 rst_n = 1'b0;
    #20;
    chk("rst_ammo", ammo, 6);
    chk("rst_reloading", reloading, 0);
    chk("rst_cooling", cooling, 0);
    chk("rst_fire_en", fire_en, 0);
    chk("rst_hit_valid", hv, 0);
    chk("rst_hit_idx", hidx, 0);
    #1 rst_n = 1'b1;

    // Hit serialisation: 1011 drains as 0,1,3; a late hit on slot 0 comes after 3.
    hit = 4'b1011; cyc();
    cyc();             chk("hs_v0", hv, 1); chk("hs_i0", hidx, 0);
    hit = 4'b0001; cyc(); chk("hs_v1", hv, 1); chk("hs_i1", hidx, 1);
    cyc();             chk("hs_v2", hv, 1); chk("hs_i2", hidx, 3);
    cyc();             chk("hs_v3", hv, 1); chk("hs_i3", hidx, 0);
    cyc();             chk("hs_idle", hv, 0);

    // Basic fire and cooldown length
    busy = 4'b0000; attack = 1'b1;
    tick_cyc();
    chk("bf_fire", fire_en, 4'b0001); chk("bf_ammo", ammo, 5); chk("bf_cool", cooling, 1);
    cyc();
    chk("bf_pulse", fire_en, 0);
    attack = 1'b0;
    frames(7);  chk("bf_cool7", cooling, 1);
    frames(1);  chk("bf_cool8", cooling, 0);

    // Slot selection and blocking
    busy = 4'b0011; attack = 1'b1;
    tick_cyc(); chk("sel_fire", fire_en, 4'b0100); chk("sel_ammo", ammo, 4);
    attack = 1'b0; frames(8);
    busy = 4'b1111; attack = 1'b1;
    tick_cyc(); chk("full_fire", fire_en, 0); chk("full_ammo", ammo, 4); chk("full_cool", cooling, 0);
    busy = 4'b0000; defend = 1'b1;
    tick_cyc(); chk("def_fire", fire_en, 0); chk("def_ammo", ammo, 4);
    defend = 1'b0;
    tick_cyc(); chk("f3_ammo", ammo, 3);
    attack = 1'b0; frames(8);

    // Manual reload at ammo 3, then a request with a full magazine
    reload_req = 1'b1; tick_cyc(); chk("mr_start", reloading, 1);
    reload_req = 1'b0;
    frames(RL - 1); chk("mr_ammo29", ammo, 3); chk("mr_rel29", reloading, 1);
    frames(1);      chk("mr_ammo", ammo, 6); chk("mr_done", reloading, 0);
    reload_req = 1'b1; tick_cyc(); chk("mr_full_ign", reloading, 0);
    reload_req = 1'b0;

    // Empty the magazine with attack held, then hold through the reload
    attack = 1'b1; fire_cnt = 0;
    frames(5 * (CD + 1) + 1);
    chk("mag_shots", fire_cnt, 6); chk("mag_ammo", ammo, 0); chk("mag_rel", reloading, 1);
    fire_cnt = 0;
    frames(RL);
    chk("rel_nofire", fire_cnt, 0); chk("rel_ammo", ammo, 6); chk("rel_done", reloading, 0);
    tick_cyc(); chk("post_fire", fire_en, 4'b0001); chk("post_ammo", ammo, 5);
    attack = 1'b0; frames(CD);

    // Async reset mid-reload (counter at 15) with hits pending
    reload_req = 1'b1; tick_cyc(); reload_req = 1'b0;
    frames(15);
    hit = 4'b1111; cyc();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar_ammo", ammo, 6); chk("ar_rel", reloading, 0); chk("ar_hv", hv, 0); chk("ar_fire", fire_en, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ar_pend_clr", hv, 0);
    end

    // Random traffic against the model
    last_tick = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick       = !last_tick && ($urandom_range(0, 2) == 0);
      last_tick  = tick;
      attack     = ($urandom_range(0, 3) != 0);
      defend     = ($urandom_range(0, 9) == 0);
      reload_req = ($urandom_range(0, 9) == 0);
      busy       = N'($urandom);
      hit        = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
